instr_fetch_unit: RTL and testbench

//  Upstream sequencer for the cpu block. Fetches 16-bit instructions from a word memory
//  at pc and presents each on cpu.in with a one-cycle load pulse. It then issues a
//  one-cycle s pulse and waits for the cpu to return to its wait state (w).

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/fetch_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 88 ++++++++
 tb/tb_instr_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu block and its instruction fetch sequencer.
// Holds the opcode constants, the fetch FSM state type and the instruction
// field slices used by the cpu decoder.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    ACK,
    EXEC,
    HALTED
  } fetch_state_t;

  // Instruction layout: [15:13] opcode, [12] mode, [10:8] rd, [7:0] imm8.
  function automatic logic [2:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[15:13];
  endfunction

  function automatic logic instr_mode(input logic [INSTR_W-1:0] instr);
    return instr[12];
  endfunction

  function automatic logic [2:0] instr_rd(input logic [INSTR_W-1:0] instr);
    return instr[10:8];
  endfunction

  function automatic logic [7:0] instr_imm8(input logic [INSTR_W-1:0] instr);
    return instr[7:0];
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch unit, the instruction memory and the cpu.
//   mem_req/mem_addr      : read request, held until mem_rvalid
//   mem_rdata/mem_rvalid  : read response
//   in/load/s             : instruction, IR load pulse and start pulse to the cpu
//   w                     : cpu wait flag (1 = cpu idle)
// master = fetch unit side, slave = memory/cpu side.
interface fetch_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] in;
  logic              load;
  logic              s;
  logic              w;

  modport master (
    output mem_req, mem_addr, in, load, s,
    input  mem_rdata, mem_rvalid, w
  );

  modport slave (
    input  mem_req, mem_addr, in, load, s,
    output mem_rdata, mem_rvalid, w
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer for the cpu block. Reads a word at pc, hands it
// to the cpu with a load pulse, starts it with an s pulse, waits for the cpu
// to leave and re-enter its wait state, then advances pc and counts the
// retired instruction. A HALT opcode parks the unit until reset.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   go         : level run enable (sampled in IDLE and at EXEC exit)
//   bus        : memory request/response and cpu in/load/s/w (fetch_if.master)
//   pc         : address of the current / next instruction
//   halted     : sticky HALT indication
//   busy       : high in every state except IDLE and HALTED
//   retired    : saturating count of completed instructions
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 9,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  fetch_if.master           bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy,
  output logic [15:0]       retired
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] in_q;
  logic [15:0]       retired_q;

  logic is_halt;
  logic accept;
  logic retire;

  assign is_halt = (instr_opcode(bus.mem_rdata) == OP_HALT);
  // rvalid is only meaningful while requesting, so it is qualified by FETCH.
  assign accept  = (state_q == FETCH) && bus.mem_rvalid && !is_halt;
  assign retire  = (state_q == EXEC) && bus.w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      in_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) in_q <= bus.mem_rdata;
      if (retire) begin
        pc_q <= pc_q + 1'b1;
        if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = FETCH;
      FETCH:   if (bus.mem_rvalid) state_d = is_halt ? HALTED : LOAD;
      LOAD:    if (bus.w) state_d = START;
      START:   state_d = ACK;
      ACK:     if (!bus.w) state_d = EXEC;
      EXEC:    if (bus.w) state_d = go ? FETCH : IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the registered state, so an async reset drops
  // mem_req, load and s in the same cycle.
  always_comb begin
    bus.mem_req  = (state_q == FETCH);
    bus.mem_addr = pc_q;
    bus.in       = in_q;
    bus.load     = (state_q == LOAD) && bus.w;
    bus.s        = (state_q == START);
    halted       = (state_q == HALTED);
    busy         = (state_q != IDLE) && (state_q != HALTED);
    pc           = pc_q;
    retired      = retired_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int SEL_BUSY = 0, SEL_HALT = 1, SEL_S = 2, SEL_REQ = 3;

  logic clk = 1'b0;
  logic reset;
  logic go_a, go_b;
  logic [8:0]  pc_a, pc_b;
  logic        halted_a, halted_b, busy_a, busy_b;
  logic [15:0] retired_a, retired_b;

  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(9), .DATA_W(16)) bus_a ();
  fetch_if #(.ADDR_W(9), .DATA_W(16)) bus_b ();

  instr_fetch_unit #(.ADDR_W(9), .DATA_W(16), .RESET_PC(9'h000)) dut_a (
    .clk(clk), .reset(reset), .go(go_a), .bus(bus_a),
    .pc(pc_a), .halted(halted_a), .busy(busy_a), .retired(retired_a)
  );

  instr_fetch_unit #(.ADDR_W(9), .DATA_W(16), .RESET_PC(9'h1FF)) dut_b (
    .clk(clk), .reset(reset), .go(go_b), .bus(bus_b),
    .pc(pc_b), .halted(halted_b), .busy(busy_b), .retired(retired_b)
  );

  // memory and cpu models, index 0 = dut_a, 1 = dut_b
  logic [15:0] mem [2][512];
  int          lat;
  int          exec_len;
  logic        rv_q [2];
  logic [15:0] rd_q [2];
  int          mcnt [2];
  logic        w_q  [2];
  int          wcnt [2];
  logic        rv_force;
  logic [15:0] rv_force_data;

  logic        req [2];
  logic [8:0]  addr [2];
  logic        ld [2];
  logic        st [2];
  logic [15:0] din [2];
  logic        bsy [2];
  logic        hlt [2];

  assign req[0] = bus_a.mem_req;  assign req[1] = bus_b.mem_req;
  assign addr[0] = bus_a.mem_addr; assign addr[1] = bus_b.mem_addr;
  assign ld[0] = bus_a.load;      assign ld[1] = bus_b.load;
  assign st[0] = bus_a.s;         assign st[1] = bus_b.s;
  assign din[0] = bus_a.in;       assign din[1] = bus_b.in;
  assign bsy[0] = busy_a;         assign bsy[1] = busy_b;
  assign hlt[0] = halted_a;       assign hlt[1] = halted_b;

  assign bus_a.mem_rvalid = rv_q[0] | rv_force;
  assign bus_a.mem_rdata  = rv_force ? rv_force_data : rd_q[0];
  assign bus_a.w          = w_q[0];
  assign bus_b.mem_rvalid = rv_q[1];
  assign bus_b.mem_rdata  = rd_q[1];
  assign bus_b.w          = w_q[1];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rv_q[i] <= 1'b0; rd_q[i] <= '0; mcnt[i] <= 0; w_q[i] <= 1'b1; wcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rv_q[i] <= 1'b0;
        if (req[i] && !rv_q[i]) begin
          if (mcnt[i] + 1 >= lat) begin
            rv_q[i] <= 1'b1; rd_q[i] <= mem[i][addr[i]]; mcnt[i] <= 0;
          end else mcnt[i] <= mcnt[i] + 1;
        end else mcnt[i] <= 0;
        if (st[i]) begin
          w_q[i] <= 1'b0; wcnt[i] <= exec_len;
        end else if (wcnt[i] > 0) begin
          wcnt[i] <= wcnt[i] - 1;
          if (wcnt[i] == 1) w_q[i] <= 1'b1;
        end
      end
    end
  end

  // protocol monitor
  int          load_cnt [2];
  int          s_cnt [2];
  int          req_cnt [2];
  int          addr_viol [2];
  int          ls_viol;
  int          s_no_load;
  logic        pend [2];
  logic        prev_req [2];
  logic [8:0]  prev_addr [2];
  logic [15:0] last_in [2];
  logic [8:0]  load_pc_b [$];

  initial begin
    ls_viol = 0; s_no_load = 0;
    for (int i = 0; i < 2; i++) begin
      load_cnt[i] = 0; s_cnt[i] = 0; req_cnt[i] = 0; addr_viol[i] = 0;
      pend[i] = 1'b0; prev_req[i] = 1'b0; prev_addr[i] = '0; last_in[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        prev_req[i] = 1'b0; pend[i] = 1'b0;
      end else begin
        if (ld[i] && st[i]) ls_viol++;
        if (ld[i]) begin
          load_cnt[i]++; last_in[i] = din[i]; pend[i] = 1'b1;
          if (i == 1) load_pc_b.push_back(pc_b);
        end
        if (st[i]) begin
          s_cnt[i]++;
          if (!pend[i]) s_no_load++;
          pend[i] = 1'b0;
        end
        if (req[i]) begin
          req_cnt[i]++;
          if (prev_req[i] && addr[i] != prev_addr[i]) addr_viol[i]++;
        end
        prev_req[i] = req[i]; prev_addr[i] = addr[i];
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic get_sig(input int sel, input int i);
    case (sel)
      SEL_BUSY: return bsy[i];
      SEL_HALT: return hlt[i];
      SEL_S:    return st[i];
      default:  return req[i];
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int i, input logic lvl, input string tag);
    int k = 0;
    while (get_sig(sel, i) !== lvl && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int ld0, r0, v0;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 512; j++) mem[i][j] = 16'hE000;
    reset = 1'b1; go_a = 1'b0; go_b = 1'b0; lat = 1; exec_len = 3;
    rv_force = 1'b0; rv_force_data = '0;
    repeat (3) step();

    // reset values
    check_val("rst_pc_a", 32'(pc_a), 32'h000);
    check_val("rst_pc_b", 32'(pc_b), 32'h1FF);
    check_val("rst_req", 32'(bus_a.mem_req), 32'd0);
    check_val("rst_ctl", {29'd0, bus_a.load, bus_a.s, halted_a}, 32'd0);
    check_val("rst_busy_in", {15'd0, busy_a, bus_a.in}, 32'd0);
    check_val("rst_retired", 32'(retired_a), 32'd0);
    reset = 1'b0;
    step();

    // single instruction
    mem[0][0] = 16'hD105;
    go_a = 1'b1;
    wait_sig(SEL_BUSY, 0, 1'b1, "t2_start");
    go_a = 1'b0;
    wait_sig(SEL_BUSY, 0, 1'b0, "t2_done");
    check_val("t2_loads", 32'(load_cnt[0]), 32'd1);
    check_val("t2_s", 32'(s_cnt[0]), 32'd1);
    check_val("t2_in", 32'(last_in[0]), 32'hD105);
    check_val("t2_pc", 32'(pc_a), 32'd1);
    check_val("t2_retired", 32'(retired_a), 32'd1);

    // reset mid-EXEC
    mem[0][1] = 16'hD105; exec_len = 8;
    go_a = 1'b1;
    wait_sig(SEL_S, 0, 1'b1, "t1e_s");
    step(); step();
    check_val("t1e_pre_busy", {31'd0, busy_a}, 32'd1);
    check_val("t1e_pre_req", {31'd0, bus_a.mem_req}, 32'd0);
    go_a = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_val("t1e_req", {29'd0, bus_a.mem_req, bus_a.load, bus_a.s}, 32'd0);
    check_val("t1e_pc", 32'(pc_a), 32'd0);
    check_val("t1e_retired", 32'(retired_a), 32'd0);
    check_val("t1e_busy", {31'd0, busy_a}, 32'd0);
    step(); reset = 1'b0; exec_len = 3;
    step();

    // reset mid-FETCH
    lat = 8;
    go_a = 1'b1;
    wait_sig(SEL_REQ, 0, 1'b1, "t1f_req");
    step(); step();
    check_val("t1f_pre_req", {31'd0, bus_a.mem_req}, 32'd1);
    go_a = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_val("t1f_req", {29'd0, bus_a.mem_req, bus_a.load, bus_a.s}, 32'd0);
    check_val("t1f_busy_pc", {22'd0, busy_a, pc_a}, 32'd0);
    step(); reset = 1'b0; lat = 1;
    step();

    // HALT
    mem[0][0] = 16'hD105; mem[0][1] = 16'hE000;
    ld0 = load_cnt[0];
    go_a = 1'b1;
    wait_sig(SEL_HALT, 0, 1'b1, "t3_halt");
    check_val("t3_pc", 32'(pc_a), 32'd1);
    check_val("t3_retired", 32'(retired_a), 32'd1);
    check_val("t3_busy", {31'd0, busy_a}, 32'd0);
    check_val("t3_loads", 32'(load_cnt[0] - ld0), 32'd1);
    check_val("t3_in", 32'(bus_a.in), 32'hD105);
    r0 = req_cnt[0];
    repeat (10) step();
    check_val("t3_no_req", 32'(req_cnt[0] - r0), 32'd0);
    check_val("t3_sticky", {31'd0, halted_a}, 32'd1);
    go_a = 1'b0;

    // spurious rvalid in IDLE, then 5-cycle latency
    reset = 1'b1; step(); step(); reset = 1'b0; step();
    ld0 = load_cnt[0]; r0 = req_cnt[0];
    rv_force_data = 16'hD1FF; rv_force = 1'b1;
    repeat (3) step();
    rv_force = 1'b0;
    check_val("t4_spur_busy", {31'd0, busy_a}, 32'd0);
    check_val("t4_spur_in", 32'(bus_a.in), 32'd0);
    check_val("t4_spur_load", 32'(load_cnt[0] - ld0), 32'd0);
    lat = 5; mem[0][0] = 16'hA123;
    r0 = req_cnt[0]; v0 = addr_viol[0];
    go_a = 1'b1;
    wait_sig(SEL_BUSY, 0, 1'b1, "t4_start");
    go_a = 1'b0;
    wait_sig(SEL_BUSY, 0, 1'b0, "t4_done");
    check_val("t4_req_cycles", 32'(req_cnt[0] - r0), 32'd6);
    check_val("t4_addr_stable", 32'(addr_viol[0] - v0), 32'd0);
    check_val("t4_loads", 32'(load_cnt[0] - ld0), 32'd1);
    check_val("t4_in", 32'(bus_a.in), 32'hA123);
    check_val("t4_pc_ret", {7'd0, pc_a, retired_a}, {7'd0, 9'd1, 16'd1});
    lat = 1;

    // go dropped during EXEC, then resume
    mem[0][1] = 16'hD10A; mem[0][2] = 16'hE000;
    go_a = 1'b1;
    wait_sig(SEL_S, 0, 1'b1, "t6_s");
    step(); step();
    check_val("t6_in_exec", {30'd0, busy_a, bus_a.w}, 32'd2);
    go_a = 1'b0;
    wait_sig(SEL_BUSY, 0, 1'b0, "t6_idle");
    check_val("t6_pc", 32'(pc_a), 32'd2);
    check_val("t6_retired", 32'(retired_a), 32'd2);
    check_val("t6_in", 32'(bus_a.in), 32'hD10A);
    go_a = 1'b1;
    wait_sig(SEL_REQ, 0, 1'b1, "t6_req");
    check_val("t6_resume_addr", 32'(bus_a.mem_addr), 32'd2);
    wait_sig(SEL_HALT, 0, 1'b1, "t6_halt");
    check_val("t6_halt_pc", 32'(pc_a), 32'd2);
    go_a = 1'b0;

    // pc wrap and retired saturation on dut_b
    check_val("t5_pc_init", 32'(pc_b), 32'h1FF);
    mem[1][9'h1FF] = 16'hD105; mem[1][0] = 16'hA123; mem[1][1] = 16'hE000;
    force dut_b.retired_q = 16'hFFFE;
    step();
    release dut_b.retired_q;
    step();
    check_val("t5_forced", 32'(retired_b), 32'hFFFE);
    go_b = 1'b1;
    wait_sig(SEL_HALT, 1, 1'b1, "t5_halt");
    go_b = 1'b0;
    check_val("t5_pc", 32'(pc_b), 32'd1);
    check_val("t5_retired", 32'(retired_b), 32'hFFFF);
    check_val("t5_loads", 32'(load_cnt[1]), 32'd2);
    check_val("t5_log_len", 32'(load_pc_b.size()), 32'd2);
    if (load_pc_b.size() >= 2) begin
      check_val("t5_pc_first", 32'(load_pc_b[0]), 32'h1FF);
      check_val("t5_pc_wrap", 32'(load_pc_b[1]), 32'h000);
    end

    check_val("load_s_overlap", 32'(ls_viol), 32'd0);
    check_val("s_without_load", 32'(s_no_load), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
